// File: rtl/pulse_gate_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_gate_ctrl
// Measurement-window controller placed after a pulse counter. It opens the
// counter enable for exactly GATE_CYCLES clocks, then spends one LATCH cycle
// with the enable low. During that cycle it captures the counter value, which
// is still the final window count because the counter clears only at the edge
// that ends LATCH. The captured count is presented on a valid/ready handshake,
// together with a per-window wrap flag and a sticky overrun flag.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle start request, honoured only in IDLE
//   i_stop         abort; forces IDLE at the next edge and suppresses capture
//   i_continuous   sampled in LATCH: 1 = open the next window immediately
//   o_cnt_en       counter enable, high only in GATE
//   i_pulse_cnt    running count from the pulse counter
//   o_result       captured window count
//   o_wrap         the counter wrapped during the window held in o_result
//   o_valid        o_result is available
//   i_ready        consumer accepts the result when o_valid & i_ready
//   o_overrun      sticky: an unaccepted result was overwritten
//   o_busy         high in GATE or LATCH
// -----------------------------------------------------------------------------
module pulse_gate_ctrl #(
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 24,
   parameter int GATE_CYCLES = 50000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_continuous,
   output logic             o_cnt_en,
   input  logic [CNT_W-1:0] i_pulse_cnt,
   output logic [CNT_W-1:0] o_result,
   output logic             o_wrap,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_overrun,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GATE  = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   // The gate counter runs GATE_CYCLES-1 down to 0, one value per GATE cycle.
   localparam logic [GATE_W-1:0] LP_GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

   state_t             r_state;
   logic [GATE_W-1:0]  r_gate_cnt;
   logic [CNT_W-1:0]   r_prev;
   logic               r_wrap_win;
   logic [CNT_W-1:0]   r_result;
   logic               r_wrap;
   logic               r_valid;
   logic               r_overrun;
   logic               r_cnt_en;
   logic               r_busy;

   // A running count that goes backwards can only mean the counter wrapped.
   logic w_count_dropped;
   assign w_count_dropped = (i_pulse_cnt < r_prev);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_gate_cnt <= '0;
         r_prev     <= '0;
         r_wrap_win <= 1'b0;
         r_result   <= '0;
         r_wrap     <= 1'b0;
         r_valid    <= 1'b0;
         r_overrun  <= 1'b0;
         r_cnt_en   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         // Accept first; a LATCH capture in the same cycle re-asserts valid below.
         if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end

         if (i_stop) begin
            // Abort wins over start and over capture; a held result stays valid.
            r_state  <= ST_IDLE;
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_start) begin
                     r_state    <= ST_GATE;
                     r_gate_cnt <= LP_GATE_LOAD;
                     r_prev     <= '0;
                     r_wrap_win <= 1'b0;
                     r_cnt_en   <= 1'b1;
                     r_busy     <= 1'b1;
                     r_overrun  <= 1'b0;
                  end
               end

               ST_GATE: begin
                  r_prev <= i_pulse_cnt;
                  if (w_count_dropped) begin
                     r_wrap_win <= 1'b1;
                  end
                  if (r_gate_cnt == '0) begin
                     r_state  <= ST_LATCH;
                     r_cnt_en <= 1'b0;
                  end else begin
                     r_gate_cnt <= r_gate_cnt - 1'b1;
                  end
               end

               ST_LATCH: begin
                  r_result <= i_pulse_cnt;
                  r_wrap   <= r_wrap_win | w_count_dropped;
                  r_valid  <= 1'b1;
                  if (r_valid && !i_ready) begin
                     r_overrun <= 1'b1;
                  end
                  if (i_continuous) begin
                     // Back-to-back window: overrun history is kept.
                     r_state    <= ST_GATE;
                     r_gate_cnt <= LP_GATE_LOAD;
                     r_prev     <= '0;
                     r_wrap_win <= 1'b0;
                     r_cnt_en   <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end

               default: begin
                  r_state  <= ST_IDLE;
                  r_cnt_en <= 1'b0;
                  r_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_cnt_en  = r_cnt_en;
   assign o_result  = r_result;
   assign o_wrap    = r_wrap;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;
   assign o_busy    = r_busy;

endmodule
